pipeline_run_monitor: RTL and testbench

//  Synthesizable run controller and writeback tracer for PipelinedProcessor.
//  - Sequences the core's reset and counts run cycles.
//  - Detects halt (PC stalled) or timeout.
//  - Captures every register-file write into a trace FIFO that a host drains via valid/ready.
//  - Replaces fixed-delay reset/run/$monitor bench control with parametrised on-chip logic.

---
 rtl/pipeline_run_monitor.sv | 230 +++++++++++++++++++++++
 tb/tb_pipeline_run_monitor.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_run_monitor.sv
// -----------------------------------------------------------------------------
// pipeline_run_monitor
//
// Run controller and writeback tracer for PipelinedProcessor.
//   * Holds the core in reset for RESET_CYCLES edges after the monitor leaves
//     reset, then lets it run and counts run cycles.
//   * Declares HALTED when the core PC has stayed unchanged long enough, or
//     TIMEOUT when the run-cycle budget is exhausted. Both are terminal until
//     the next monitor reset.
//   * Records every traced register-file write as {timestamp, addr, data} in a
//     show-ahead FIFO that a host drains with a valid/ready handshake.
//
// Ports
//   clk          in   rising-edge clock for all logic
//   reset        in   synchronous, active-low monitor reset (0 = reset)
//   core_reset   out  active-high reset for the processor core
//   pc_in        in   core program counter
//   wb_en        in   register-file write enable
//   wb_addr      in   register-file write index
//   wb_data      in   register-file write data
//   trace_valid  out  FIFO head entry is valid
//   trace_ready  in   host accepts the head entry this cycle
//   trace_data   out  head entry {timestamp, addr, data}
//   cycle_count  out  run cycles elapsed (frozen once done)
//   status       out  0 RESET_HOLD, 1 RUN, 2 HALTED, 3 TIMEOUT
//   done         out  status is HALTED or TIMEOUT
//   overflow     out  sticky flag: at least one trace entry was dropped
//   drop_count   out  number of dropped entries, saturating at 255
// -----------------------------------------------------------------------------
module pipeline_run_monitor #(
    parameter int PC_WIDTH       = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CYC_WIDTH      = 16,
    parameter int RESET_CYCLES   = 2,
    parameter int MAX_CYCLES     = 1000,
    parameter int HALT_WINDOW    = 4,
    parameter int TRACE_DEPTH    = 16,
    parameter int FILTER_R0      = 1
) (
    input  logic                                          clk,
    input  logic                                          reset,
    output logic                                          core_reset,
    input  logic [PC_WIDTH-1:0]                           pc_in,
    input  logic                                          wb_en,
    input  logic [REG_ADDR_WIDTH-1:0]                     wb_addr,
    input  logic [DATA_WIDTH-1:0]                         wb_data,
    output logic                                          trace_valid,
    input  logic                                          trace_ready,
    output logic [CYC_WIDTH+REG_ADDR_WIDTH+DATA_WIDTH-1:0] trace_data,
    output logic [CYC_WIDTH-1:0]                          cycle_count,
    output logic [1:0]                                    status,
    output logic                                          done,
    output logic                                          overflow,
    output logic [7:0]                                    drop_count
);

    localparam int ENTRY_W = CYC_WIDTH + REG_ADDR_WIDTH + DATA_WIDTH;
    localparam int HOLD_W  = $clog2(RESET_CYCLES + 1);
    localparam int STAB_W  = $clog2(HALT_WINDOW);
    localparam int PTR_W   = $clog2(TRACE_DEPTH);

    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [STAB_W-1:0]    STAB_MAX  = STAB_W'(HALT_WINDOW - 1);
    localparam logic [CYC_WIDTH-1:0] CYC_LAST  = CYC_WIDTH'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RESET_HOLD = 2'd0,
        ST_RUN        = 2'd1,
        ST_HALTED     = 2'd2,
        ST_TIMEOUT    = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Run-control state
    // -------------------------------------------------------------------------
    state_t                state_q,    state_d;
    logic [HOLD_W-1:0]     hold_q,     hold_d;
    logic [CYC_WIDTH-1:0]  cyc_q,      cyc_d;
    logic [STAB_W-1:0]     stable_q,   stable_d;
    logic [PC_WIDTH-1:0]   pc_prev_q,  pc_prev_d;
    // Set once a RUN-cycle PC has been captured, so the very first RUN cycle
    // never compares against a PC sampled while the core was still in reset.
    logic                  pc_valid_q, pc_valid_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_RESET_HOLD;
            hold_q     <= '0;
            cyc_q      <= '0;
            stable_q   <= '0;
            pc_prev_q  <= '0;
            pc_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            cyc_q      <= cyc_d;
            stable_q   <= stable_d;
            pc_prev_q  <= pc_prev_d;
            pc_valid_q <= pc_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        cyc_d      = cyc_q;
        stable_d   = stable_q;
        pc_prev_d  = pc_prev_q;
        pc_valid_d = pc_valid_q;

        case (state_q)
            ST_RESET_HOLD: begin
                pc_valid_d = 1'b0;
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end

            ST_RUN: begin
                pc_prev_d  = pc_in;
                pc_valid_d = 1'b1;
                if (pc_valid_q) begin
                    if (pc_in == pc_prev_q) begin
                        // Saturate so a long halt cannot wrap the counter.
                        if (stable_q != STAB_MAX) begin
                            stable_d = stable_q + STAB_W'(1);
                        end
                    end else begin
                        stable_d = '0;
                    end
                end

                // Halt takes priority over timeout; in either case the cycle
                // counter keeps the value of the last RUN cycle.
                if (stable_q == STAB_MAX) begin
                    state_d = ST_HALTED;
                end else if (cyc_q == CYC_LAST) begin
                    state_d = ST_TIMEOUT;
                end else begin
                    cyc_d = cyc_q + CYC_WIDTH'(1);
                end
            end

            ST_HALTED, ST_TIMEOUT: begin
                // Terminal: everything holds until the next monitor reset.
            end

            default: begin
                state_d = ST_RESET_HOLD;
            end
        endcase
    end

    assign status      = state_q;
    assign core_reset  = (state_q == ST_RESET_HOLD);
    assign done        = (state_q == ST_HALTED) || (state_q == ST_TIMEOUT);
    assign cycle_count = cyc_q;

    // -------------------------------------------------------------------------
    // Trace FIFO
    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // without a separate occupancy counter.
    // -------------------------------------------------------------------------
    logic [ENTRY_W-1:0] mem_q [TRACE_DEPTH];
    logic [PTR_W:0]     wr_ptr_q,   wr_ptr_d;
    logic [PTR_W:0]     rd_ptr_q,   rd_ptr_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         drops_q,    drops_d;

    logic               fifo_empty;
    logic               fifo_full;
    logic               push_req;
    logic               push_ok;
    logic               pop;
    logic               drop;
    logic [ENTRY_W-1:0] push_entry;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign push_req   = (state_q == ST_RUN) && wb_en &&
                        !((FILTER_R0 != 0) && (wb_addr == '0));
    assign pop        = !fifo_empty && trace_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push_ok    = push_req && (!fifo_full || pop);
    assign drop       = push_req && fifo_full && !pop;
    assign push_entry = {cyc_q, wb_addr, wb_data};

    always_comb begin
        wr_ptr_d   = wr_ptr_q + ((PTR_W + 1)'(push_ok));
        rd_ptr_d   = rd_ptr_q + ((PTR_W + 1)'(pop));
        overflow_d = overflow_q | drop;
        drops_d    = drops_q;
        if (drop && (drops_q != 8'hFF)) begin
            drops_d = drops_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            drops_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            drops_q    <= drops_d;
        end
    end

    // Storage carries no reset; emptiness is defined purely by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= push_entry;
        end
    end

    // Show-ahead read: the head entry is presented without waiting for a pop.
    assign trace_data  = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign trace_valid = !fifo_empty;
    assign overflow    = overflow_q;
    assign drop_count  = drops_q;

endmodule

// File: tb/tb_pipeline_run_monitor.sv
// -----------------------------------------------------------------------------
// tb_pipeline_run_monitor
//
// Directed bench for pipeline_run_monitor with RESET_CYCLES=3, MAX_CYCLES=20,
// HALT_WINDOW=4, TRACE_DEPTH=4, FILTER_R0=1. Expected values are worked out by
// hand from the cycle numbering noted beside each step. "cycle N" below means
// the RUN cycle in which cycle_count should read N; outputs are sampled 1 ns
// after the rising edge that starts that cycle.
// -----------------------------------------------------------------------------
module tb_pipeline_run_monitor;

    localparam int PCW = 32;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int CW  = 16;
    localparam int EW  = CW + AW + DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_reset;
    logic [PCW-1:0] pc_in;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          trace_valid;
    logic          trace_ready;
    logic [EW-1:0] trace_data;
    logic [CW-1:0] cycle_count;
    logic [1:0]    status;
    logic          done;
    logic          overflow;
    logic [7:0]    drop_count;

    int  err_cnt = 0;
    int  chk_cnt = 0;
    bit  pc_auto = 1'b0;

    always #5 clk = ~clk;

    pipeline_run_monitor #(
        .PC_WIDTH       (PCW),
        .DATA_WIDTH     (DW),
        .REG_ADDR_WIDTH (AW),
        .CYC_WIDTH      (CW),
        .RESET_CYCLES   (3),
        .MAX_CYCLES     (20),
        .HALT_WINDOW    (4),
        .TRACE_DEPTH    (4),
        .FILTER_R0      (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .core_reset  (core_reset),
        .pc_in       (pc_in),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .trace_valid (trace_valid),
        .trace_ready (trace_ready),
        .trace_data  (trace_data),
        .cycle_count (cycle_count),
        .status      (status),
        .done        (done),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, act);
        end
    endtask

    // Expected trace entry {timestamp, addr, data}, zero-extended to 64 bits.
    function automatic logic [63:0] ent(input int ts, input int a, input logic [31:0] d);
        logic [CW-1:0] t16;
        logic [AW-1:0] a5;
        t16 = CW'(ts);
        a5  = AW'(a);
        return {11'b0, t16, a5, d};
    endfunction

    // Advance one clock; optionally step the PC so the core never looks halted.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pc_auto) pc_in = pc_in + 32'd4;
    endtask

    // Monitor reset then release; returns in RUN cycle 0.
    task automatic run_reset();
        reset       = 1'b0;
        wb_en       = 1'b0;
        trace_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();
        tick();
    endtask

    initial begin
        reset       = 1'b0;
        pc_in       = '0;
        wb_en       = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;
        trace_ready = 1'b0;

        // ---- Reset state and release sequencing --------------------------
        tick();
        tick();                           // edge 0: last edge with reset low
        check_eq("rst_status",   64'(status),      64'd0);
        check_eq("rst_core_rst", 64'(core_reset),  64'd1);
        check_eq("rst_cycles",   64'(cycle_count), 64'd0);
        check_eq("rst_valid",    64'(trace_valid), 64'd0);
        check_eq("rst_done",     64'(done),        64'd0);
        check_eq("rst_ovf",      64'(overflow),    64'd0);
        check_eq("rst_drops",    64'(drop_count),  64'd0);
        reset = 1'b1;
        // Core samples core_reset=1 at edges 1..3 and 0 from edge 4 on.
        tick();                           // after edge 1
        check_eq("hold1_core_rst", 64'(core_reset), 64'd1);
        check_eq("hold1_status",   64'(status),     64'd0);
        tick();                           // after edge 2
        check_eq("hold2_core_rst", 64'(core_reset), 64'd1);
        tick();                           // after edge 3: RUN cycle 0
        check_eq("run0_core_rst", 64'(core_reset),  64'd0);
        check_eq("run0_status",   64'(status),      64'd1);
        check_eq("run0_cycles",   64'(cycle_count), 64'd0);

        // ---- Capture with r0 filtering ------------------------------------
        pc_auto = 1'b1;
        tick();                           // cycle 1
        tick();                           // cycle 2
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h5;
        tick();                           // cycle 3
        check_eq("cap_valid_next", 64'(trace_valid), 64'd1);
        wb_addr = 5'd0; wb_data = 32'h9;
        tick();                           // cycle 4
        wb_en = 1'b0;
        check_eq("cap_head",   64'(trace_data),  ent(2, 1, 32'h5));
        check_eq("cap_cycles", 64'(cycle_count), 64'd4);
        trace_ready = 1'b1;
        tick();                           // cycle 5: single entry popped, r0 never queued
        check_eq("cap_drained", 64'(trace_valid), 64'd0);
        trace_ready = 1'b0;

        // ---- Halt detection ----------------------------------------------
        pc_auto = 1'b0;
        pc_in   = '0;
        run_reset();                      // cycle 0, pc=0x0
        for (int k = 1; k <= 8; k++) begin
            tick();
            pc_in = 32'(k * 4);           // cycle k, pc=4k (0x20 at cycle 8)
        end
        tick();                           // cycle 9: first repeat of 0x20
        tick();
        tick();
        tick();                           // cycle 12
        check_eq("halt_not_yet", 64'(status), 64'd1);
        tick();                           // cycle 13 = first repeat + 4
        check_eq("halt_status", 64'(status),      64'd2);
        check_eq("halt_done",   64'(done),        64'd1);
        check_eq("halt_cycles", 64'(cycle_count), 64'd12);
        check_eq("halt_core",   64'(core_reset),  64'd0);
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
        tick();
        wb_en = 1'b0;
        check_eq("halt_no_cap",  64'(trace_valid), 64'd0);
        check_eq("halt_frozen",  64'(cycle_count), 64'd12);

        // ---- Timeout -------------------------------------------------------
        pc_auto = 1'b1;
        run_reset();
        for (int k = 1; k <= 19; k++) tick();
        check_eq("to_last_run", 64'(status),      64'd1);
        check_eq("to_last_cyc", 64'(cycle_count), 64'd19);
        tick();                           // run cycle 20
        check_eq("to_status", 64'(status),      64'd3);
        check_eq("to_done",   64'(done),        64'd1);
        check_eq("to_cycles", 64'(cycle_count), 64'd19);
        tick();
        check_eq("to_frozen", 64'(cycle_count), 64'd19);
        check_eq("to_sticky", 64'(status),      64'd3);

        // ---- Halt and timeout in the same cycle: halt wins ---------------
        pc_auto = 1'b1;
        run_reset();
        for (int k = 1; k <= 15; k++) tick();
        pc_auto = 1'b0;                   // PC frozen from cycle 15
        for (int k = 16; k <= 19; k++) tick();
        check_eq("both_pre", 64'(status), 64'd1);
        tick();
        check_eq("both_halted", 64'(status),      64'd2);
        check_eq("both_cycles", 64'(cycle_count), 64'd19);

        // ---- FIFO overflow, full push+pop, drain, empty pop ---------------
        pc_auto = 1'b1;
        run_reset();
        for (int k = 0; k < 6; k++) begin
            wb_en = 1'b1; wb_addr = AW'(k + 1); wb_data = 32'h100 + 32'(k);
            tick();                       // write captured in cycle k
        end
        wb_en = 1'b0;                     // cycle 6
        check_eq("ovf_valid", 64'(trace_valid), 64'd1);
        check_eq("ovf_flag",  64'(overflow),    64'd1);
        check_eq("ovf_drops", 64'(drop_count),  64'd2);
        check_eq("ovf_head",  64'(trace_data),  ent(0, 1, 32'h100));
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h200; trace_ready = 1'b1;
        tick();                           // cycle 7
        wb_en = 1'b0;
        check_eq("fp_head",  64'(trace_data), ent(1, 2, 32'h101));
        check_eq("fp_drops", 64'(drop_count), 64'd2);
        tick();                           // cycle 8
        check_eq("drain_e3", 64'(trace_data), ent(2, 3, 32'h102));
        tick();                           // cycle 9
        check_eq("drain_e4", 64'(trace_data), ent(3, 4, 32'h103));
        tick();                           // cycle 10
        check_eq("drain_e7", 64'(trace_data), ent(6, 7, 32'h200));
        tick();                           // cycle 11
        check_eq("drain_empty", 64'(trace_valid), 64'd0);
        tick();                           // cycle 12: pop while empty did nothing
        check_eq("empty_pop", 64'(trace_valid), 64'd0);
        wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h88;
        tick();                           // cycle 13
        check_eq("one_head", 64'(trace_data), ent(12, 8, 32'h88));
        wb_addr = 5'd9; wb_data = 32'h99;
        tick();                           // cycle 14: push+pop with one entry
        wb_en = 1'b0;
        check_eq("pp_valid", 64'(trace_valid), 64'd1);
        check_eq("pp_head",  64'(trace_data),  ent(13, 9, 32'h99));
        tick();                           // cycle 15
        check_eq("pp_empty",   64'(trace_valid), 64'd0);
        check_eq("ovf_sticky", 64'(overflow),    64'd1);

        // ---- Reset mid-run discards queued entries ------------------------
        trace_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wb_en = 1'b1; wb_addr = AW'(10 + k); wb_data = 32'hA0 + 32'(k);
            tick();                       // cycles 15..17
        end
        wb_en = 1'b0;                     // cycle 18
        check_eq("mid_head", 64'(trace_data), ent(15, 10, 32'hA0));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_eq("mid_valid",  64'(trace_valid), 64'd0);
        check_eq("mid_status", 64'(status),      64'd0);
        check_eq("mid_core",   64'(core_reset),  64'd1);
        check_eq("mid_ovf",    64'(overflow),    64'd0);
        check_eq("mid_drops",  64'(drop_count),  64'd0);
        check_eq("mid_cycles", 64'(cycle_count), 64'd0);
        check_eq("mid_done",   64'(done),        64'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
